// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand loader.
// Holds the sequencer state encoding, operand widths and header beat order.
package matrix_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned MAX_DIM = 3;
    localparam int unsigned IDX_W   = $clog2(MAX_DIM);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoadA,
        StLoadB,
        StStart,
        StWaitDone,
        StError
    } state_e;

    // Index of the header beat expected next.
    localparam logic [1:0] HDR_R1 = 2'd0;
    localparam logic [1:0] HDR_C1 = 2'd1;
    localparam logic [1:0] HDR_R2 = 2'd2;
    localparam logic [1:0] HDR_C2 = 2'd3;

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (d <= DATA_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_load_ctrl_if.sv
// Nibble input stream, operand-buffer write port and compute handshake.
interface matrix_load_ctrl_if;
    import matrix_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              ctrl_logic;
    logic [DATA_W-1:0] data;
    logic              wr_en;
    logic              wr_sel;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] c1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] c2;
    logic              start;
    logic              done_i;
    logic              busy;
    logic              err;

    modport slave (
        input  in_valid, ctrl_logic, data, done_i,
        output in_ready, wr_en, wr_sel, wr_row, wr_col, wr_data,
        output r1, c1, r2, c2, start, busy, err
    );

    modport master (
        output in_valid, ctrl_logic, data, done_i,
        input  in_ready, wr_en, wr_sel, wr_row, wr_col, wr_data,
        input  r1, c1, r2, c2, start, busy, err
    );

endinterface

// File: rtl/matrix_rc_counter.sv
// Row-major (row, col) walker with runtime limits; last_o flags (R-1, C-1).
module matrix_rc_counter
    import matrix_pkg::*;
#(
    parameter int unsigned DataW = DATA_W,
    parameter int unsigned IdxW  = IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DataW-1:0] rows_i,
    input  logic [DataW-1:0] cols_i,
    output logic [IdxW-1:0]  row_o,
    output logic [IdxW-1:0]  col_o,
    output logic             last_o
);

    logic [IdxW-1:0] row_q, row_d, col_q, col_d;
    logic            row_end, col_end;

    assign row_end = DataW'(row_q) == rows_i - DataW'(1);
    assign col_end = DataW'(col_q) == cols_i - DataW'(1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + IdxW'(1);
            end else begin
                col_d = col_q + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_end && col_end;

endmodule

// File: rtl/matrix_load_ctrl.sv
// Matrix operand loader sequencer: header check, A/B buffer writes, compute launch.
module matrix_load_ctrl
    import matrix_pkg::*;
(
    input logic               CLK,
    input logic               RST_N,
    matrix_load_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [DATA_W-1:0] r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
    logic              wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
    logic [IDX_W-1:0]  wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              start_q;

    logic              acc_hdr, acc_elem;
    logic              cnt_clr, cnt_en, cnt_last;
    logic [DATA_W-1:0] lim_rows, lim_cols;
    logic [IDX_W-1:0]  cnt_row, cnt_col;

    assign bus.in_ready = (state_q != StStart) && (state_q != StWaitDone);
    assign acc_hdr      = bus.in_valid && bus.in_ready && bus.ctrl_logic;
    assign acc_elem     = bus.in_valid && bus.in_ready && !bus.ctrl_logic;

    assign lim_rows = (state_q == StLoadB) ? r2_q : r1_q;
    assign lim_cols = (state_q == StLoadB) ? c2_q : c1_q;

    matrix_rc_counter #(
        .DataW(DATA_W),
        .IdxW (IDX_W)
    ) u_rc_counter (
        .clk_i (CLK),
        .rst_ni(RST_N),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .rows_i(lim_rows),
        .cols_i(lim_cols),
        .row_o (cnt_row),
        .col_o (cnt_col),
        .last_o(cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        r1_d      = r1_q;
        c1_d      = c1_q;
        r2_d      = r2_q;
        c2_d      = c2_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle, StError: begin
                if (acc_hdr) begin
                    r1_d      = bus.data;
                    hdr_idx_d = HDR_C1;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (acc_elem) begin
                    state_d = StError;
                end else if (acc_hdr) begin
                    case (hdr_idx_q)
                        HDR_C1: begin
                            c1_d      = bus.data;
                            hdr_idx_d = HDR_R2;
                        end
                        HDR_R2: begin
                            r2_d      = bus.data;
                            hdr_idx_d = HDR_C2;
                        end
                        default: begin
                            c2_d = bus.data;
                            // c2 is checked straight off the bus, it is not latched yet.
                            if (dim_ok(r1_q) && dim_ok(c1_q) && dim_ok(r2_q) &&
                                dim_ok(bus.data) && (c1_q == r2_q)) begin
                                cnt_clr = 1'b1;
                                state_d = StLoadA;
                            end else begin
                                state_d = StError;
                            end
                        end
                    endcase
                end
            end
            StLoadA, StLoadB: begin
                if (acc_hdr) begin
                    state_d = StError;
                end else if (acc_elem) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == StLoadB);
                    wr_row_d  = cnt_row;
                    wr_col_d  = cnt_col;
                    wr_data_d = bus.data;
                    cnt_en    = 1'b1;
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = (state_q == StLoadA) ? StLoadB : StStart;
                    end
                end
            end
            StStart:    state_d = StWaitDone;
            StWaitDone: if (bus.done_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            hdr_idx_q <= HDR_R1;
            r1_q      <= '0;
            c1_q      <= '0;
            r2_q      <= '0;
            c2_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            r1_q      <= r1_d;
            c1_q      <= c1_d;
            r2_q      <= r2_d;
            c2_q      <= c2_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            // Delayed one cycle past StStart so the final B write lands first.
            start_q   <= (state_q == StStart);
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_row  = wr_row_q;
    assign bus.wr_col  = wr_col_q;
    assign bus.wr_data = wr_data_q;
    assign bus.r1      = r1_q;
    assign bus.c1      = c1_q;
    assign bus.r2      = r2_q;
    assign bus.c2      = c2_q;
    assign bus.start   = start_q;
    assign bus.err     = (state_q == StError);
    assign bus.busy    = (state_q != StIdle) && (state_q != StError);

endmodule
